ray_sweep_cell: RTL and testbench

//  Per-square ray cell for the systolic move generator; one instance per board square, neighbours wired point-to-point.

---
 rtl/ray_sweep_cell.sv | 164 ++++++++++++++++
 tb/tb_ray_sweep_cell.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ray_sweep_cell.sv
// Per-square ray cell: launches range-limited sliding rays for the resident piece and
// records, filters and forwards rays arriving from neighbouring squares during a sweep.
module ray_sweep_cell #(
  parameter int unsigned NUM_DIR      = 8,
  parameter int unsigned POS_W        = 6,
  parameter int unsigned RANGE_W      = 3,
  parameter int unsigned SWEEP_CYCLES = 7,
  localparam int unsigned MSG_W       = 4 + RANGE_W + POS_W,
  localparam int unsigned CNT_W       = $clog2(NUM_DIR + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ack,
  input  logic [POS_W-1:0]           pos,
  input  logic                       piece_vld,
  input  logic                       piece_color,
  input  logic [1:0]                 piece_slide,
  input  logic [RANGE_W-1:0]         piece_range,
  input  logic [NUM_DIR*MSG_W-1:0]   ray_in,
  output logic [NUM_DIR*MSG_W-1:0]   ray_out,
  output logic [NUM_DIR*MSG_W-1:0]   move_q,
  output logic [NUM_DIR-1:0]         move_vld,
  output logic [NUM_DIR-1:0]         capture,
  output logic [CNT_W-1:0]           move_count,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned SC_W = $clog2(SWEEP_CYCLES + 1);
  localparam int unsigned RHI  = POS_W + RANGE_W - 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [SC_W-1:0]          cnt_q, cnt_d;
  logic [NUM_DIR*MSG_W-1:0] ray_out_q, ray_out_d;
  logic [NUM_DIR*MSG_W-1:0] move_msg_q, move_msg_d;
  logic [NUM_DIR-1:0]       move_vld_q, move_vld_d;
  logic [NUM_DIR-1:0]       capture_q, capture_d;
  logic [CNT_W-1:0]         move_count_q, move_count_d;

  always_comb begin
    logic [MSG_W-1:0]   m;
    logic [1:0]         cls;
    logic [RANGE_W-1:0] rng;
    logic               cls_ok;
    logic               slide_ok;
    logic               accept;
    logic               rec;
    logic               cap;
    int unsigned        o;

    state_d    = state_q;
    cnt_d      = cnt_q;
    ray_out_d  = '0;
    move_msg_d = move_msg_q;
    move_vld_d = move_vld_q;
    capture_d  = capture_q;
    m          = '0;
    cls        = '0;
    rng        = '0;
    cls_ok     = 1'b0;
    slide_ok   = 1'b0;
    accept     = 1'b0;
    rec        = 1'b0;
    cap        = 1'b0;
    o          = 0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        move_msg_d = '0;
        move_vld_d = '0;
        capture_d  = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
          slide_ok = (d % 2 == 0) ? piece_slide[0] : piece_slide[1];
          if (piece_vld && slide_ok && (piece_range != '0))
            ray_out_d[d*MSG_W +: MSG_W] = {1'b1, piece_color, piece_slide, piece_range, pos};
        end
        cnt_d   = SC_W'(1);
        state_d = S_SWEEP;
      end
      S_SWEEP: begin
        // Forward target o is fed only by its opposite d, so slots never collide.
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
          m      = ray_in[d*MSG_W +: MSG_W];
          cls    = m[MSG_W-3 -: 2];
          rng    = m[RHI -: RANGE_W];
          cls_ok = (d % 2 == 0) ? cls[0] : cls[1];
          accept = m[MSG_W-1] && (rng != '0) && cls_ok;
          o      = (d + NUM_DIR / 2) % NUM_DIR;
          rec    = 1'b0;
          cap    = 1'b0;
          if (accept) begin
            if (piece_vld) begin
              if (m[MSG_W-2] != piece_color) begin
                rec = 1'b1;
                cap = 1'b1;
              end
            end else begin
              rec = 1'b1;
              if (rng > RANGE_W'(1))
                ray_out_d[o*MSG_W +: MSG_W] = {m[MSG_W-1:RHI+1], rng - RANGE_W'(1), m[POS_W-1:0]};
            end
          end
          if (rec && !move_vld_q[d]) begin
            move_msg_d[d*MSG_W +: MSG_W] = m;
            move_vld_d[d]                = 1'b1;
            capture_d[d]                 = cap;
          end
        end
        if (cnt_q == SC_W'(SWEEP_CYCLES)) begin
          ray_out_d = '0;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + SC_W'(1);
        end
      end
      default: begin
        if (ack) state_d = S_IDLE;
      end
    endcase

    move_count_d = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++)
      move_count_d = move_count_d + CNT_W'(move_vld_d[d]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ray_out_q    <= '0;
      move_msg_q   <= '0;
      move_vld_q   <= '0;
      capture_q    <= '0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ray_out_q    <= ray_out_d;
      move_msg_q   <= move_msg_d;
      move_vld_q   <= move_vld_d;
      capture_q    <= capture_d;
      move_count_q <= move_count_d;
    end
  end

  assign ray_out    = ray_out_q;
  assign move_q     = move_msg_q;
  assign move_vld   = move_vld_q;
  assign capture    = capture_q;
  assign move_count = move_count_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_ray_sweep_cell.sv
// Directed bench for ray_sweep_cell: launch patterns, capture/block filtering,
// forwarding with range decrement, sticky recording, sweep length and reset abort.
module tb_ray_sweep_cell;

  logic         clk;
  logic         reset;
  logic         start;
  logic         ack;
  logic [5:0]   pos;
  logic         piece_vld;
  logic         piece_color;
  logic [1:0]   piece_slide;
  logic [2:0]   piece_range;
  logic [103:0] ray_in;
  logic [103:0] ray_out;
  logic [103:0] move_q;
  logic [7:0]   move_vld;
  logic [7:0]   capture;
  logic [3:0]   move_count;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  ray_sweep_cell #(
    .NUM_DIR      (8),
    .POS_W        (6),
    .RANGE_W      (3),
    .SWEEP_CYCLES (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .pos         (pos),
    .piece_vld   (piece_vld),
    .piece_color (piece_color),
    .piece_slide (piece_slide),
    .piece_range (piece_range),
    .ray_in      (ray_in),
    .ray_out     (ray_out),
    .move_q      (move_q),
    .move_vld    (move_vld),
    .capture     (capture),
    .move_count  (move_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic v, input logic c, input logic [1:0] cls,
                                     input logic [2:0] r, input logic [5:0] o);
    return {v, c, cls, r, o};
  endfunction

  function automatic logic [103:0] sl(input int d, input logic [12:0] m);
    logic [103:0] t;
    t = '0;
    t[d*13 +: 13] = m;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start pulse: leaves the cell in SWEEP cycle 1 with launched rays visible
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    logic [103:0] exp_v;

    reset = 1'b1; start = 1'b0; ack = 1'b0; pos = 6'd27;
    piece_vld = 1'b0; piece_color = 1'b0; piece_slide = 2'b00; piece_range = 3'd0;
    ray_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ray_out", ray_out, 0);
    chk("rst_move_vld", move_vld, 0);
    chk("rst_busy_done", {busy, done}, 0);

    // white queen at 27, range 7: every direction launches
    piece_vld = 1'b1; piece_color = 1'b0; piece_slide = 2'b11; piece_range = 3'd7;
    go();
    exp_v = '0;
    for (int d = 0; d < 8; d++) exp_v |= sl(d, mk(1'b1, 1'b0, 2'b11, 3'd7, 6'd27));
    chk("queen_launch", ray_out, exp_v);
    chk("queen_busy", {busy, done}, 2'b10);

    // black diagonal ray on dir 3 -> capture, no forward from occupied square
    ray_in = sl(3, mk(1'b1, 1'b1, 2'b10, 3'd4, 6'd5));
    tick();
    chk("cap_vld", move_vld, 8'h08);
    chk("cap_flag", capture, 8'h08);
    chk("cap_count", move_count, 4'd1);
    chk("cap_move_q", move_q, sl(3, mk(1'b1, 1'b1, 2'b10, 3'd4, 6'd5)));
    chk("cap_no_fwd", ray_out, 0);

    // same-colour rays are blocked
    ray_in = sl(3, mk(1'b1, 1'b0, 2'b10, 3'd4, 6'd9)) | sl(5, mk(1'b1, 1'b0, 2'b10, 3'd2, 6'd1));
    tick();
    chk("block_vld", move_vld, 8'h08);
    chk("block_cap", capture, 8'h08);

    // reset in SWEEP cycle 3 aborts everything
    ray_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ray_out", ray_out, 0);
    chk("abort_move_q", move_q, 0);
    chk("abort_flags", {move_vld, capture, move_count, busy, done}, 0);

    // rook launches on even (manhattan) slices only
    piece_slide = 2'b01; piece_range = 3'd3;
    go();
    exp_v = '0;
    for (int d = 0; d < 8; d += 2) exp_v |= sl(d, mk(1'b1, 1'b0, 2'b01, 3'd3, 6'd27));
    chk("rook_launch", ray_out, exp_v);
    for (int i = 0; i < 6; i++) tick();
    chk("rook_cyc7_not_done", {busy, done}, 2'b10);
    tick();
    chk("rook_done", {busy, done, ray_out}, {2'b11, 104'd0});
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("done_held", {busy, done}, 2'b11);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", {busy, done}, 2'b00);

    // empty square: quiet moves, forwarding with range decrement
    piece_vld = 1'b0; pos = 6'd20;
    go();
    chk("empty_launch", ray_out, 0);
    ray_in = sl(0, mk(1'b1, 1'b0, 2'b01, 3'd3, 6'd12));
    tick();
    chk("fwd_vld", move_vld, 8'h01);
    chk("fwd_cap", capture, 8'h00);
    chk("fwd_move_q", move_q, sl(0, mk(1'b1, 1'b0, 2'b01, 3'd3, 6'd12)));
    chk("fwd_ray4", ray_out, sl(4, mk(1'b1, 1'b0, 2'b01, 3'd2, 6'd12)));

    // dir2 first arrival, range-1 on dir6 (no forward), manhattan on diagonal dir1 (drop)
    ray_in = sl(2, mk(1'b1, 1'b1, 2'b01, 3'd4, 6'd33))
           | sl(6, mk(1'b1, 1'b0, 2'b01, 3'd1, 6'd40))
           | sl(1, mk(1'b1, 1'b0, 2'b01, 3'd5, 6'd7));
    tick();
    chk("multi_vld", move_vld, 8'h45);
    chk("multi_count", move_count, 4'd3);
    chk("multi_ray", ray_out, sl(6, mk(1'b1, 1'b1, 2'b01, 3'd3, 6'd33)));
    ray_in = '0;
    tick();
    chk("idle_ray_zero", ray_out, 0);
    tick();

    // second dir2 arrival in cycle 5: forwarded, not recorded
    ray_in = sl(2, mk(1'b1, 1'b0, 2'b01, 3'd6, 6'd50));
    tick();
    chk("second_fwd", ray_out, sl(6, mk(1'b1, 1'b0, 2'b01, 3'd5, 6'd50)));
    exp_v = sl(0, mk(1'b1, 1'b0, 2'b01, 3'd3, 6'd12))
          | sl(2, mk(1'b1, 1'b1, 2'b01, 3'd4, 6'd33))
          | sl(6, mk(1'b1, 1'b0, 2'b01, 3'd1, 6'd40));
    chk("sticky_move_q", move_q, exp_v);

    // range 0 message is invalid
    ray_in = sl(4, mk(1'b1, 1'b0, 2'b01, 3'd0, 6'd3));
    tick();
    chk("range0_drop", move_vld, 8'h45);
    ray_in = '0;
    tick();
    chk("sweep_done", {busy, done, ray_out}, {2'b11, 104'd0});

    ray_in = sl(4, mk(1'b1, 1'b0, 2'b01, 3'd3, 6'd3));
    tick();
    chk("done_ignores_ray_in", move_vld, 8'h45);
    ray_in = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_hold", {move_vld, move_count, busy, done}, {8'h45, 4'd3, 2'b00});
    chk("idle_hold_q", move_q, exp_v);

    go();
    chk("relaunch_clear", {move_vld, capture, move_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
